// File: rtl/buffer_read_client_if.sv
// Memory read-arbiter burst bus between buffer_read_client (master) and the arbiter (slave).
interface buffer_read_client_if #(
  parameter int ADDR_WIDTH = 21
);
  logic                  mem_rd_req;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic                  mem_rd_ack;
  logic                  mem_rd_done;

  modport master (
    output mem_rd_req,
    output mem_rd_addr,
    input  mem_rd_ack,
    input  mem_rd_done
  );

  modport slave (
    input  mem_rd_req,
    input  mem_rd_addr,
    output mem_rd_ack,
    output mem_rd_done
  );
endinterface

// File: rtl/buffer_read_client.sv
// Read-side requester for the triple-buffer controller: per display frame it obtains a
// buffer grant, streams the buffer as fixed-length bursts paced by FIFO space, then releases it.
module buffer_read_client #(
  parameter int ADDR_WIDTH    = 21,
  parameter int BURST_LEN     = 16,
  parameter int FRAME_WORDS   = 65280,
  parameter int BUFFER_STRIDE = 65536
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_start,
  output logic                 read_rq_rdy,
  input  logic                 buffer_id_valid,
  input  logic [1:0]           buffer_id,
  output logic                 finalize_rd,
  buffer_read_client_if.master mem,
  input  logic                 fifo_ready,
  output logic                 busy,
  output logic                 frame_skipped
);

  localparam int NUM_BURSTS = FRAME_WORDS / BURST_LEN;
  localparam int CNT_W      = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
  localparam logic [CNT_W-1:0] LAST_BURST = CNT_W'(NUM_BURSTS - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ISSUE,
    WAIT_DONE,
    RELEASE
  } state_t;

  state_t                state, state_nx;
  logic [CNT_W-1:0]      burst_cnt, burst_cnt_nx;
  logic [1:0]            cur_id, cur_id_nx;
  logic                  rq, rq_nx;
  logic                  req, req_nx;
  logic [ADDR_WIDTH-1:0] addr, addr_nx;
  logic                  fin, fin_nx;
  logic                  busy_r, busy_nx;
  logic                  skip, skip_nx;
  logic [ADDR_WIDTH-1:0] burst_addr;

  assign burst_addr = ADDR_WIDTH'(cur_id) * ADDR_WIDTH'(BUFFER_STRIDE)
                    + ADDR_WIDTH'(burst_cnt) * ADDR_WIDTH'(BURST_LEN);

  always_comb begin
    state_nx     = state;
    burst_cnt_nx = burst_cnt;
    cur_id_nx    = cur_id;
    rq_nx        = rq;
    req_nx       = req;
    addr_nx      = addr;
    fin_nx       = 1'b0;
    busy_nx      = busy_r;
    skip_nx      = frame_start && (state != IDLE);

    unique case (state)
      IDLE: begin
        if (frame_start) begin
          state_nx     = REQ;
          rq_nx        = 1'b1;
          busy_nx      = 1'b1;
          burst_cnt_nx = '0;
        end
      end
      REQ: begin
        if (buffer_id_valid) begin
          cur_id_nx = buffer_id;
          rq_nx     = 1'b0;
          state_nx  = ISSUE;
        end
      end
      ISSUE: begin
        if (!req) begin
          if (fifo_ready) begin
            req_nx  = 1'b1;
            addr_nx = burst_addr;
          end
        end else if (mem.mem_rd_ack) begin
          req_nx = 1'b0;
          // A done arriving with the ack belongs to this burst, so skip WAIT_DONE.
          if (mem.mem_rd_done) begin
            burst_cnt_nx = burst_cnt + 1'b1;
            if (burst_cnt == LAST_BURST) begin
              state_nx = RELEASE;
              fin_nx   = 1'b1;
            end else begin
              state_nx = ISSUE;
            end
          end else begin
            state_nx = WAIT_DONE;
          end
        end
      end
      WAIT_DONE: begin
        if (mem.mem_rd_done) begin
          burst_cnt_nx = burst_cnt + 1'b1;
          if (burst_cnt == LAST_BURST) begin
            state_nx = RELEASE;
            fin_nx   = 1'b1;
          end else begin
            state_nx = ISSUE;
          end
        end
      end
      RELEASE: begin
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      burst_cnt <= '0;
      cur_id    <= '0;
      rq        <= 1'b0;
      req       <= 1'b0;
      addr      <= '0;
      fin       <= 1'b0;
      busy_r    <= 1'b0;
      skip      <= 1'b0;
    end else begin
      state     <= state_nx;
      burst_cnt <= burst_cnt_nx;
      cur_id    <= cur_id_nx;
      rq        <= rq_nx;
      req       <= req_nx;
      addr      <= addr_nx;
      fin       <= fin_nx;
      busy_r    <= busy_nx;
      skip      <= skip_nx;
    end
  end

  assign read_rq_rdy     = rq;
  assign finalize_rd     = fin;
  assign busy            = busy_r;
  assign frame_skipped   = skip;
  assign mem.mem_rd_req  = req;
  assign mem.mem_rd_addr = addr;

endmodule

// File: tb/tb_buffer_read_client.sv
// Scoreboard bench for buffer_read_client: the bench plays controller, memory arbiter and FIFO.
module tb_buffer_read_client;

  localparam int AW     = 21;
  localparam int BL     = 4;
  localparam int FW     = 16;
  localparam int STRIDE = 256;
  localparam int NB     = FW / BL;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_start;
  logic       read_rq_rdy;
  logic       buffer_id_valid;
  logic [1:0] buffer_id;
  logic       finalize_rd;
  logic       fifo_ready;
  logic       busy;
  logic       frame_skipped;

  buffer_read_client_if #(.ADDR_WIDTH(AW)) mem ();

  buffer_read_client #(
    .ADDR_WIDTH    (AW),
    .BURST_LEN     (BL),
    .FRAME_WORDS   (FW),
    .BUFFER_STRIDE (STRIDE)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .frame_start     (frame_start),
    .read_rq_rdy     (read_rq_rdy),
    .buffer_id_valid (buffer_id_valid),
    .buffer_id       (buffer_id),
    .finalize_rd     (finalize_rd),
    .mem             (mem),
    .fifo_ready      (fifo_ready),
    .busy            (busy),
    .frame_skipped   (frame_skipped)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [AW-1:0] exp_addr[$];
  int fin_seen  = 0;
  int skip_seen = 0;
  int exp_skip  = 0;
  int rise_cnt  = 0;
  int force_ad  = -1;
  int force_dd  = -1;
  int fifo_mode = 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory arbiter: random (or forced) ack latency, done 0..3 cycles after ack (0 = same cycle).
  initial begin
    int ad, dd;
    mem.mem_rd_ack  = 1'b0;
    mem.mem_rd_done = 1'b0;
    forever begin
      @(negedge clk);
      if (mem.mem_rd_req && !reset) begin
        ad = (force_ad >= 0) ? force_ad : int'($urandom_range(0, 5));
        dd = (force_dd >= 0) ? force_dd : int'($urandom_range(0, 3));
        repeat (ad) @(negedge clk);
        mem.mem_rd_ack  = 1'b1;
        mem.mem_rd_done = (dd == 0);
        @(negedge clk);
        mem.mem_rd_ack  = 1'b0;
        mem.mem_rd_done = 1'b0;
        if (dd > 0) begin
          repeat (dd - 1) @(negedge clk);
          mem.mem_rd_done = 1'b1;
          @(negedge clk);
          mem.mem_rd_done = 1'b0;
        end
      end
    end
  end

  // FIFO space: 0 = random, 1 = always ready, 2 = never ready.
  initial begin
    fifo_ready = 1'b1;
    forever begin
      @(negedge clk);
      #1;
      fifo_ready = (fifo_mode == 0) ? ($urandom_range(0, 3) != 0) : (fifo_mode == 1);
    end
  end

  // Monitor: pops the expected burst address on every new request, checks pulses and holds.
  initial begin
    logic          prev_req;
    logic          prev_fin;
    logic [AW-1:0] prev_addr;
    logic [AW-1:0] want;
    prev_req  = 1'b0;
    prev_fin  = 1'b0;
    prev_addr = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_req = 1'b0;
        prev_fin = 1'b0;
      end else begin
        if (mem.mem_rd_req && !prev_req) begin
          rise_cnt++;
          check("req_needs_fifo_ready", fifo_ready, 1);
          if (exp_addr.size() == 0) begin
            check("req_was_expected", exp_addr.size() != 0, 1);
          end else begin
            want = exp_addr.pop_front();
            check("req_addr", mem.mem_rd_addr, want);
          end
        end else if (mem.mem_rd_req && prev_req) begin
          check("req_addr_stable", mem.mem_rd_addr, prev_addr);
        end
        if (frame_skipped) skip_seen++;
        if (finalize_rd) begin
          fin_seen++;
          check("fin_rq_low", read_rq_rdy, 0);
          check("fin_all_bursts_issued", exp_addr.size(), 0);
          check("fin_busy_high", busy, 1);
        end
        if (prev_fin) begin
          check("fin_one_cycle", finalize_rd, 0);
          check("post_fin_rq_low", read_rq_rdy, 0);
          check("post_fin_busy_low", busy, 0);
        end
        prev_req  = mem.mem_rd_req;
        prev_addr = mem.mem_rd_addr;
        prev_fin  = finalize_rd;
      end
    end
  end

  task automatic push_frame(input logic [1:0] id);
    for (int k = 0; k < NB; k++) exp_addr.push_back(AW'(int'(id) * STRIDE + k * BL));
  endtask

  task automatic run_frame(input logic [1:0] id, input int gdly, input bit hold2,
                           input bit mid_skip, input bit rel_skip, input bit fifo_gap);
    int base;
    int i;
    base = fin_seen;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    @(negedge clk);
    check("rq_after_frame_start", read_rq_rdy, 1);
    check("busy_after_frame_start", busy, 1);
    for (int g = 0; g < gdly; g++) begin
      @(negedge clk);
      check("rq_held_until_grant", read_rq_rdy, 1);
    end
    tick();
    buffer_id_valid = 1'b1;
    buffer_id       = id;
    push_frame(id);
    tick();
    if (hold2) buffer_id = 2'd0;
    else buffer_id_valid = 1'b0;
    @(negedge clk);
    check("rq_drop_after_grant", read_rq_rdy, 0);
    if (hold2) begin
      tick();
      buffer_id_valid = 1'b0;
    end
    if (fifo_gap) begin
      i = 0;
      do begin
        @(negedge clk);
        i++;
      end while (!mem.mem_rd_req && i < 50);
      check("gap_first_req_seen", mem.mem_rd_req, 1);
      fifo_mode = 2;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        check("gap_no_req", mem.mem_rd_req, 0);
      end
      fifo_mode = 1;
      @(negedge clk);
      check("req_after_fifo_rise", mem.mem_rd_req, 1);
      check("req_addr_after_fifo_rise", mem.mem_rd_addr, AW'(int'(id) * STRIDE + BL));
    end
    if (mid_skip) begin
      repeat (2) tick();
      frame_start = 1'b1;
      exp_skip++;
      tick();
      frame_start = 1'b0;
    end
    i = 0;
    while (!finalize_rd && i < 3000) begin
      @(negedge clk);
      i++;
    end
    check("finalize_within_budget", finalize_rd, 1);
    if (rel_skip) begin
      frame_start = 1'b1;
      exp_skip++;
      tick();
      frame_start = 1'b0;
    end else begin
      tick();
    end
    repeat (2) tick();
    check("finalize_count", fin_seen, base + 1);
    check("skip_count", skip_seen, exp_skip);
    check("idle_busy_low", busy, 0);
    check("idle_rq_low", read_rq_rdy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rq"}, read_rq_rdy, 0);
    check({tag, "_fin"}, finalize_rd, 0);
    check({tag, "_req"}, mem.mem_rd_req, 0);
    check({tag, "_addr"}, mem.mem_rd_addr, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_skip"}, frame_skipped, 0);
  endtask

  initial begin
    int r0;
    int i;
    reset           = 1'b1;
    frame_start     = 1'b0;
    buffer_id_valid = 1'b0;
    buffer_id       = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    repeat (2) tick();

    // Grant after 3 cycles, buffer 2, FIFO stall before the second burst.
    force_ad = 0;
    force_dd = 1;
    run_frame(2'd2, 3, 1'b0, 1'b0, 1'b0, 1'b1);

    // Grant held two cycles with the id changing on the second.
    force_ad = -1;
    force_dd = -1;
    run_frame(2'd2, 2, 1'b1, 1'b0, 1'b0, 1'b0);

    // Slow ack with coincident done; frame_start mid-frame and during release.
    force_ad = 5;
    force_dd = 0;
    run_frame(2'd1, 1, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (5) tick();
    check("no_request_without_new_frame", read_rq_rdy, 0);
    check("no_busy_without_new_frame", busy, 0);

    // Reset during burst 3 of a frame.
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (2) tick();
    buffer_id_valid = 1'b1;
    buffer_id       = 2'd1;
    push_frame(2'd1);
    tick();
    buffer_id_valid = 1'b0;
    r0 = rise_cnt;
    i  = 0;
    while (rise_cnt < r0 + 3 && i < 500) begin
      @(negedge clk);
      i++;
    end
    check("reached_burst3", rise_cnt, r0 + 3);
    check("busy_before_reset", busy, 1);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    exp_addr.delete();
    repeat (12) @(posedge clk);
    #1;
    reset = 1'b0;
    force_ad = -1;
    force_dd = -1;
    repeat (2) tick();
    run_frame(2'd0, 2, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomised frames with random FIFO backpressure and memory latency.
    fifo_mode = 0;
    for (int f = 0; f < 6; f++) begin
      run_frame(2'($urandom_range(0, 2)), int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end
    fifo_mode = 1;
    check("queue_drained", exp_addr.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    total++;
    bad++;
    $display("FAIL watchdog: simulation still running at %0t, limit 2000000", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
